// File: rtl/axi_dw_rd_slot_sched_if.sv
// -----------------------------------------------------------------------------
// axi_dw_rd_slot_sched_if
//   Control-only bundle between the data-width converter's AR demux / per-slot
//   R beat generators and the read-slot scheduler.
//
//   slave modport  : scheduler view
//     inputs   ar_valid_i, ar_id_i, r_req_i, r_last_i, r_ready_i
//     outputs  ar_ready_o, ar_slot_o, slot_busy_o, r_gnt_o, r_valid_o, r_sel_o
//   master modport : surrounding converter view (directions mirrored)
// -----------------------------------------------------------------------------
interface axi_dw_rd_slot_sched_if #(
  parameter int NumSlots = 4,
  parameter int IdWidth  = 4
);
  localparam int SlotIdxW = $clog2(NumSlots);

  // AR side
  logic                ar_valid_i;
  logic [IdWidth-1:0]  ar_id_i;
  logic                ar_ready_o;
  logic [SlotIdxW-1:0] ar_slot_o;
  logic [NumSlots-1:0] slot_busy_o;

  // R side
  logic [NumSlots-1:0] r_req_i;
  logic [NumSlots-1:0] r_last_i;
  logic [NumSlots-1:0] r_gnt_o;
  logic                r_valid_o;
  logic [SlotIdxW-1:0] r_sel_o;
  logic                r_ready_i;

  modport slave (
    input  ar_valid_i, ar_id_i, r_req_i, r_last_i, r_ready_i,
    output ar_ready_o, ar_slot_o, slot_busy_o, r_gnt_o, r_valid_o, r_sel_o
  );

  modport master (
    output ar_valid_i, ar_id_i, r_req_i, r_last_i, r_ready_i,
    input  ar_ready_o, ar_slot_o, slot_busy_o, r_gnt_o, r_valid_o, r_sel_o
  );
endinterface

// File: rtl/axi_dw_rd_slot_sched.sv
// -----------------------------------------------------------------------------
// axi_dw_rd_slot_sched
//   Read-slot scheduler for the AXI data-width converter read path.
//   Allocates the lowest free read slot to each accepted AR and arbitrates the
//   R channel round-robin among slots with pending beats. A burst, once
//   started, keeps the grant until its last beat (burst lock). An age matrix
//   keeps same-ID bursts in allocation order.
//
//   Ports
//     clk_i   clock
//     rst_ni  asynchronous reset, active low
//     bus     axi_dw_rd_slot_sched_if.slave (AR allocation + R arbitration)
//
//   Optional feature (compile-time macro AXI_DW_RD_SCHED_ID_STALL_EN):
//     defined     : an AR whose ID matches any busy slot is stalled until that
//                   slot frees (at most one outstanding burst per ID).
//     not defined : same-ID ARs take separate slots; ordering relies solely on
//                   the age-matrix eligibility rule.
// -----------------------------------------------------------------------------
module axi_dw_rd_slot_sched #(
  parameter int NumSlots = 4,
  parameter int IdWidth  = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  axi_dw_rd_slot_sched_if.slave       bus
);
  localparam int SlotIdxW = $clog2(NumSlots);
  typedef logic [SlotIdxW-1:0] slot_idx_t;
  typedef logic [NumSlots-1:0] slot_vec_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  slot_vec_t                        busy_q,  busy_d;
  logic [NumSlots-1:0][IdWidth-1:0] id_q,    id_d;
  // older_q[j][k] : slot j was allocated before slot k
  logic [NumSlots-1:0][NumSlots-1:0] older_q, older_d;
  logic                             lock_q,      lock_d;
  slot_idx_t                        lock_slot_q, lock_slot_d;
  slot_idx_t                        rr_ptr_q,    rr_ptr_d;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic          alloc_found;
  slot_idx_t     alloc_idx;
  logic          id_stall;
  logic          ar_ready;
  logic          ar_hs;
  slot_vec_t     blocked;
  slot_vec_t     elig;
  slot_vec_t     gnt;
  slot_idx_t     sel;
  logic          rr_found;
  logic [SlotIdxW:0] idx_w;
  logic          r_valid;
  logic          r_hs;
  slot_idx_t     sel_next;

  // Allocation: lowest free slot, judged on registered busy only, so a slot
  // freed this cycle becomes allocatable one cycle later.
  // NOTE: every variable written in an always_comb gets a default at the top;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (!alloc_found && !busy_q[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = slot_idx_t'(i);
      end
    end

    id_stall = 1'b0;
`ifdef AXI_DW_RD_SCHED_ID_STALL_EN
    for (int i = 0; i < NumSlots; i++) begin
      if (busy_q[i] && (id_q[i] == bus.ar_id_i)) id_stall = bus.ar_valid_i;
    end
`endif

    ar_ready = alloc_found & ~id_stall;
    ar_hs    = bus.ar_valid_i & ar_ready;
  end

  // Eligibility: a requesting slot waits while an older busy slot with the
  // same ID still holds beats.
  always_comb begin
    blocked = '0;
    for (int i = 0; i < NumSlots; i++) begin
      for (int j = 0; j < NumSlots; j++) begin
        if ((j != i) && busy_q[j] && (id_q[j] == id_q[i]) && older_q[j][i])
          blocked[i] = 1'b1;
      end
    end
    elig = busy_q & bus.r_req_i & ~blocked;
  end

  // Arbitration: locked slot keeps the grant; otherwise round-robin from
  // rr_ptr_q over eligible slots.
  always_comb begin
    gnt      = '0;
    sel      = '0;
    rr_found = 1'b0;
    idx_w    = '0;
    if (lock_q) begin
      if (bus.r_req_i[lock_slot_q]) begin
        gnt[lock_slot_q] = 1'b1;
        sel              = lock_slot_q;
      end
    end else begin
      for (int off = 0; off < NumSlots; off++) begin
        idx_w = {1'b0, rr_ptr_q} + (SlotIdxW+1)'(off);
        if (idx_w >= (SlotIdxW+1)'(NumSlots)) idx_w = idx_w - (SlotIdxW+1)'(NumSlots);
        if (!rr_found && elig[idx_w[SlotIdxW-1:0]]) begin
          rr_found = 1'b1;
          sel      = idx_w[SlotIdxW-1:0];
        end
      end
      if (rr_found) gnt[sel] = 1'b1;
    end
    r_valid  = |gnt;
    r_hs     = r_valid & bus.r_ready_i;
    sel_next = (sel == slot_idx_t'(NumSlots-1)) ? '0 : sel + slot_idx_t'(1);
  end

  // Next-state
  always_comb begin
    busy_d      = busy_q;
    id_d        = id_q;
    older_d     = older_q;
    lock_d      = lock_q;
    lock_slot_d = lock_slot_q;
    rr_ptr_d    = rr_ptr_q;

    if (r_hs) begin
      if (bus.r_last_i[sel]) begin
        lock_d      = 1'b0;
        rr_ptr_d    = sel_next;
        busy_d[sel] = 1'b0;
      end else begin
        lock_d      = 1'b1;
        lock_slot_d = sel;
      end
    end else if (r_valid) begin
      // Downstream stalled: pin the grant so r_gnt_o/r_sel_o cannot move
      // until the offered beat is taken.
      lock_d      = 1'b1;
      lock_slot_d = sel;
    end

    if (ar_hs) begin
      busy_d[alloc_idx] = 1'b1;
      id_d[alloc_idx]   = bus.ar_id_i;
      for (int j = 0; j < NumSlots; j++) older_d[j][alloc_idx] = busy_q[j];
      older_d[alloc_idx] = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q      <= '0;
      older_q     <= '0;
      lock_q      <= 1'b0;
      lock_slot_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      busy_q      <= busy_d;
      older_q     <= older_d;
      lock_q      <= lock_d;
      lock_slot_q <= lock_slot_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // NOTE: the per-slot ID store is deliberately left without reset; it is
  // only ever read qualified by busy_q, which is reset.
  always_ff @(posedge clk_i) begin
    id_q <= id_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.ar_ready_o  = ar_ready;
  assign bus.ar_slot_o   = alloc_idx;
  assign bus.slot_busy_o = busy_q;
  assign bus.r_gnt_o     = gnt;
  assign bus.r_valid_o   = r_valid;
  assign bus.r_sel_o     = sel;

endmodule

// File: tb/tb_axi_dw_rd_slot_sched.sv
// -----------------------------------------------------------------------------
// tb_axi_dw_rd_slot_sched
//   Scoreboard bench: directed stimulus pushes the expected R grant order and
//   AR slot numbers into queues; a negedge monitor pops and compares on every
//   R and AR handshake. Per-slot beat sources are modelled by beat counters.
// -----------------------------------------------------------------------------
module tb_axi_dw_rd_slot_sched;
  localparam int NS = 4;
  localparam int IW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_dw_rd_slot_sched_if #(.NumSlots(NS), .IdWidth(IW)) bus ();

  axi_dw_rd_slot_sched #(.NumSlots(NS), .IdWidth(IW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int passed = 0;
  int total  = 0;

  int exp_r[$];
  int exp_ar[$];
  int beats_left[NS];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Beat sources: slot s requests while it has beats left; last when one left.
  always_comb begin
    bus.r_req_i  = '0;
    bus.r_last_i = '0;
    for (int s = 0; s < NS; s++) begin
      bus.r_req_i[s]  = (beats_left[s] != 0);
      bus.r_last_i[s] = (beats_left[s] == 1);
    end
  end

  // Consume a beat one delta after the edge that took it.
  bit hs_seen;
  int hs_slot;
  always begin
    @(negedge clk);
    hs_seen = rst_n && bus.r_valid_o && bus.r_ready_i;
    hs_slot = int'(bus.r_sel_o);
    @(posedge clk);
    #1;
    if (hs_seen && rst_n) beats_left[hs_slot] = beats_left[hs_slot] - 1;
  end

  // Scoreboard monitor
  int mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.r_valid_o && bus.r_ready_i) begin
        if (exp_r.size() == 0) check("r_unexpected", 32'd1, 32'd0);
        else begin
          mon_e = exp_r.pop_front();
          check("r_sel", 32'(bus.r_sel_o), 32'(mon_e));
          check("r_gnt_onehot", 32'(bus.r_gnt_o), 32'(1) << mon_e);
        end
      end
      if (bus.ar_valid_i && bus.ar_ready_o) begin
        if (exp_ar.size() == 0) check("ar_unexpected", 32'd1, 32'd0);
        else begin
          mon_e = exp_ar.pop_front();
          check("ar_slot", 32'(bus.ar_slot_o), 32'(mon_e));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_ar(input int id, input int slot);
    bit ok;
    exp_ar.push_back(slot);
    bus.ar_id_i    = IW'(id);
    bus.ar_valid_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.ar_ready_o;
    end
    check("ar_accept", 32'(ok), 32'd1);
    step();
    bus.ar_valid_i = 1'b0;
  endtask

  function automatic bit all_zero();
    for (int s = 0; s < NS; s++) if (beats_left[s] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain();
    for (int i = 0; i < 200 && !all_zero(); i++) step();
    check("drain", 32'(all_zero()), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  32'(bus.slot_busy_o), 32'd0);
    check({tag, "_gnt"},   32'(bus.r_gnt_o),     32'd0);
    check({tag, "_valid"}, 32'(bus.r_valid_o),   32'd0);
    check({tag, "_sel"},   32'(bus.r_sel_o),     32'd0);
    check({tag, "_ready"}, 32'(bus.ar_ready_o),  32'd1);
  endtask

  initial begin
    bus.ar_valid_i = 1'b0;
    bus.ar_id_i    = '0;
    bus.r_ready_i  = 1'b0;
    for (int s = 0; s < NS; s++) beats_left[s] = 0;

    // ---- reset ----
    #2;
    check_reset_outputs("in_reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    check_reset_outputs("after_reset");

    // ---- 1: single AR, 4-beat burst ----
    do_ar(3, 0);
    check("t1_busy_set", 32'(bus.slot_busy_o), 32'b0001);
    bus.r_ready_i = 1'b1;
    beats_left[0] = 4;
    repeat (4) exp_r.push_back(0);
    repeat (3) step();
    @(negedge clk);
    check("t1_busy_in_last", 32'(bus.slot_busy_o), 32'b0001);
    step();
    check("t1_busy_cleared", 32'(bus.slot_busy_o), 32'b0000);
    // rr_ptr now 1

    // ---- 2: fill all slots, free/alloc same cycle ----
    do_ar(0, 0);
    do_ar(1, 1);
    do_ar(2, 2);
    do_ar(3, 3);
    check("t2_all_busy", 32'(bus.slot_busy_o), 32'b1111);
    bus.ar_id_i    = 4'd7;
    bus.ar_valid_i = 1'b1;
    @(negedge clk);
    check("t2_full_stall", 32'(bus.ar_ready_o), 32'd0);
    step();
    beats_left[2] = 1;
    exp_r.push_back(2);
    exp_ar.push_back(2);
    @(negedge clk);
    check("t2_stall_free_cycle", 32'(bus.ar_ready_o), 32'd0);
    check("t2_r_valid", 32'(bus.r_valid_o), 32'd1);
    step();
    @(negedge clk);
    check("t2_accept_next", 32'(bus.ar_ready_o), 32'd1);
    step();
    bus.ar_valid_i = 1'b0;
    check("t2_refilled", 32'(bus.slot_busy_o), 32'b1111);
    // rr_ptr = 3 -> order 3,0,1,2
    for (int s = 0; s < NS; s++) beats_left[s] = 1;
    exp_r.push_back(3); exp_r.push_back(0); exp_r.push_back(1); exp_r.push_back(2);
    wait_drain();
    check("t2_empty", 32'(bus.slot_busy_o), 32'd0);
    // rr_ptr = 3

    // ---- 3a: two 2-beat bursts, no interleave ----
    do_ar(4, 0);
    do_ar(9, 1);
    beats_left[0] = 2;
    beats_left[1] = 2;
    exp_r.push_back(0); exp_r.push_back(0); exp_r.push_back(1); exp_r.push_back(1);
    wait_drain();
    check("t3a_empty", 32'(bus.slot_busy_o), 32'd0);
    // rr_ptr = 2

    // ---- 3b: rr_ptr=1 makes slot 1 beat slot 0 on a tie ----
    do_ar(4, 0);
    do_ar(9, 1);
    do_ar(10, 2);
    beats_left[0] = 1;
    exp_r.push_back(0);
    wait_drain();
    check("t3b_partial", 32'(bus.slot_busy_o), 32'b0110);
    do_ar(11, 0);
    beats_left[0] = 1; beats_left[1] = 1; beats_left[2] = 1;
    exp_r.push_back(1); exp_r.push_back(2); exp_r.push_back(0);
    wait_drain();
    check("t3b_empty", 32'(bus.slot_busy_o), 32'd0);
    // rr_ptr = 1

`ifndef AXI_DW_RD_SCHED_ID_STALL_EN
    // ---- 4: same ID in two slots, younger requests first ----
    do_ar(5, 0);
    do_ar(5, 1);
    beats_left[1] = 2;
    repeat (3) begin
      @(negedge clk);
      check("t4_younger_blocked", 32'(bus.r_valid_o), 32'd0);
      step();
    end
    beats_left[0] = 2;
    exp_r.push_back(0); exp_r.push_back(0); exp_r.push_back(1); exp_r.push_back(1);
    wait_drain();
    check("t4_empty", 32'(bus.slot_busy_o), 32'd0);
`else
    // ---- 5: ID stall ----
    do_ar(5, 0);
    bus.ar_id_i    = 4'd5;
    bus.ar_valid_i = 1'b1;
    @(negedge clk);
    check("t5_id_stall", 32'(bus.ar_ready_o), 32'd0);
    step();
    bus.ar_valid_i = 1'b0;
    do_ar(6, 1);
    bus.ar_id_i    = 4'd5;
    bus.ar_valid_i = 1'b1;
    @(negedge clk);
    check("t5_id_stall2", 32'(bus.ar_ready_o), 32'd0);
    step();
    beats_left[0] = 1;
    exp_r.push_back(0);
    exp_ar.push_back(0);
    @(negedge clk);
    check("t5_stall_free_cycle", 32'(bus.ar_ready_o), 32'd0);
    step();
    @(negedge clk);
    check("t5_accept_next", 32'(bus.ar_ready_o), 32'd1);
    step();
    bus.ar_valid_i = 1'b0;
    beats_left[0] = 1; beats_left[1] = 1;
    exp_r.push_back(1); exp_r.push_back(0);
    wait_drain();
    check("t5_empty", 32'(bus.slot_busy_o), 32'd0);
`endif

    // ---- 6: back-pressure stability, then reset mid-burst ----
    do_ar(2, 0);
    beats_left[0] = 4;
    repeat (4) exp_r.push_back(0);
    @(negedge clk);
    step();
    bus.r_ready_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t6_hold_gnt",   32'(bus.r_gnt_o),   32'b0001);
      check("t6_hold_sel",   32'(bus.r_sel_o),   32'd0);
      check("t6_hold_valid", 32'(bus.r_valid_o), 32'd1);
      step();
    end
    bus.r_ready_i = 1'b1;
    @(negedge clk);
    step();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_burst_reset");
    for (int s = 0; s < NS; s++) beats_left[s] = 0;
    exp_r.delete();
    step();
    rst_n = 1'b1;
    do_ar(1, 0);
    beats_left[0] = 1;
    exp_r.push_back(0);
    wait_drain();
    check("t6_empty", 32'(bus.slot_busy_o), 32'd0);

    step();
    check("exp_r_drained",  32'(exp_r.size()),  32'd0);
    check("exp_ar_drained", 32'(exp_ar.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
